// File: rtl/reset_seq_pkg.sv
// Shared constants for the G-sensor board reset sequencer: FSM state codes,
// default parameter values and the width helper used to size counters.
package reset_seq_pkg;

  localparam logic [2:0] POR_WAIT  = 3'd0;
  localparam logic [2:0] RELEASE   = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] GAP       = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] HOLD      = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;

  // $clog2 that never returns 0, so a one-stage or two-cycle build still has a 1-bit field.
  function automatic int clog2Min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_STAGE_DLY  = 50000;
  localparam int DEF_TIMEOUT    = 1000000;

  localparam int IDX_W = clog2Min1(DEF_NUM_STAGES);
  localparam int DLY_W = clog2Min1(DEF_STAGE_DLY);
  localparam int TO_W  = clog2Min1(DEF_TIMEOUT);

endpackage

// File: rtl/reset_seq_timer.sv
// Clear-and-count cycle counter with a terminal-count flag; the owner clears
// it on every state change so it never needs to wrap.
module reset_seq_timer
  import reset_seq_pkg::*;
#(
  parameter int W = DLY_W
) (
  input  logic         iCLK,
  input  logic         iRSTN,
  input  logic         iCLR,
  input  logic         iEN,
  input  logic [W-1:0] iLAST,
  output logic         oTC
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN)    cnt <= '0;
    else if (iCLR) cnt <= '0;
    else if (iEN)  cnt <= cnt + W'(1);
  end

  assign oTC = iEN && (cnt == iLAST);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with per-stage done handshake, timeout error and soft
// re-sequence. Define RSTSEQ_DONE_MONITOR_EN to trap done drops while in RUN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STAGE_DLY  = DEF_STAGE_DLY,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                                iCLK,
  input  logic                                iRSTN,
  input  logic                                iSOFT_REQ,
  input  logic [NUM_STAGES-1:0]               iSTAGE_DONE,
  output logic [NUM_STAGES-1:0]               oSTAGE_RST,
  output logic                                oBUSY,
  output logic                                oALL_READY,
  output logic                                oERR,
  output logic [clog2Min1(NUM_STAGES)-1:0]    oERR_STAGE
);

  localparam int idxW = clog2Min1(NUM_STAGES);
  localparam int dlyW = clog2Min1(STAGE_DLY);
  localparam int toW  = clog2Min1(TIMEOUT);

  localparam logic [idxW-1:0] K_LAST   = idxW'(NUM_STAGES - 1);
  localparam logic [dlyW-1:0] DLY_LAST = dlyW'(STAGE_DLY - 1);
  localparam logic [toW-1:0]  TO_LAST  = toW'(TIMEOUT - 1);

  logic [2:0]      state, nextState;
  logic [idxW-1:0] k;
  logic            dlyTc, toTc, cntClr, dlyEn, toEn;

`ifdef RSTSEQ_DONE_MONITOR_EN
  logic                  doneDrop, seen;
  logic [idxW-1:0]       dropIdx;
  logic [NUM_STAGES-1:0] dropMask;

  // Lowest dropped stage and the mask of it plus everything above it.
  always_comb begin
    doneDrop = ~&iSTAGE_DONE;
    dropIdx  = '0;
    dropMask = '0;
    seen     = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (!iSTAGE_DONE[i]) dropIdx = idxW'(i);
    for (int i = 0; i < NUM_STAGES; i++) begin
      seen        = seen | ~iSTAGE_DONE[i];
      dropMask[i] = seen;
    end
  end
`endif

  // NOTE: nextState gets its default before the case, so no path infers a latch.
  always_comb begin
    nextState = state;
    case (state)
      POR_WAIT, GAP, HOLD: if (dlyTc) nextState = RELEASE;
      RELEASE:             nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (iSTAGE_DONE[k]) nextState = (k == K_LAST) ? RUN : GAP;
        else if (toTc)      nextState = ERROR;
      end
      RUN: begin
        if (iSOFT_REQ) nextState = HOLD;
`ifdef RSTSEQ_DONE_MONITOR_EN
        else if (doneDrop) nextState = ERROR;
`endif
      end
      ERROR:   if (iSOFT_REQ) nextState = HOLD;
      default: nextState = POR_WAIT;
    endcase
  end

  // Both counters restart on every state change.
  assign cntClr = (nextState != state);
  assign dlyEn  = (state == POR_WAIT) || (state == GAP) || (state == HOLD);
  assign toEn   = (state == WAIT_DONE);

  reset_seq_timer #(.W(dlyW)) uDlyTimer (
    .iCLK(iCLK), .iRSTN(iRSTN), .iCLR(cntClr), .iEN(dlyEn), .iLAST(DLY_LAST), .oTC(dlyTc)
  );

  reset_seq_timer #(.W(toW)) uToTimer (
    .iCLK(iCLK), .iRSTN(iRSTN), .iCLR(cntClr), .iEN(toEn), .iLAST(TO_LAST), .oTC(toTc)
  );

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state      <= POR_WAIT;
      k          <= '0;
      oSTAGE_RST <= '1;
      oBUSY      <= 1'b1;
      oALL_READY <= 1'b0;
      oERR       <= 1'b0;
      oERR_STAGE <= '0;
    end else begin
      state <= nextState;
      if (state == POR_WAIT && nextState == RELEASE) k <= '0;
      if (state == GAP && nextState == RELEASE)      k <= k + idxW'(1);
      if (state == RELEASE) oSTAGE_RST[k] <= 1'b0;
      if (state == WAIT_DONE && nextState == RUN) begin
        oALL_READY <= 1'b1;
        oBUSY      <= 1'b0;
        oSTAGE_RST <= '0;
      end
      if (state == WAIT_DONE && nextState == ERROR) begin
        oERR          <= 1'b1;
        oERR_STAGE    <= k;
        oSTAGE_RST[k] <= 1'b1;
        oBUSY         <= 1'b0;
      end
`ifdef RSTSEQ_DONE_MONITOR_EN
      if (state == RUN && nextState == ERROR) begin
        oERR       <= 1'b1;
        oERR_STAGE <= dropIdx;
        oSTAGE_RST <= dropMask;
        oALL_READY <= 1'b0;
        oBUSY      <= 1'b0;
      end
`endif
      // Soft re-sequence keeps oERR_STAGE for post-mortem; only oERR clears.
      if (nextState == HOLD && state != HOLD) begin
        oSTAGE_RST <= '1;
        oALL_READY <= 1'b0;
        oBUSY      <= 1'b1;
        oERR       <= 1'b0;
        k          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer (NUM_STAGES=3, STAGE_DLY=8, TIMEOUT=32);
// RUN-state checks follow RSTSEQ_DONE_MONITOR_EN when it is defined.
module tb_reset_sequencer;

  localparam int NS  = 3;
  localparam int DLY = 8;
  localparam int TO  = 32;
  localparam int INF = 1 << 30;

  logic          iCLK = 1'b0;
  logic          iRSTN = 1'b0;
  logic          iSOFT_REQ = 1'b0;
  logic [NS-1:0] iSTAGE_DONE = '0;
  logic [NS-1:0] oSTAGE_RST;
  logic          oBUSY, oALL_READY, oERR;
  logic [1:0]    oERR_STAGE;

  reset_sequencer #(.NUM_STAGES(NS), .STAGE_DLY(DLY), .TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iSOFT_REQ(iSOFT_REQ), .iSTAGE_DONE(iSTAGE_DONE),
    .oSTAGE_RST(oSTAGE_RST), .oBUSY(oBUSY), .oALL_READY(oALL_READY),
    .oERR(oERR), .oERR_STAGE(oERR_STAGE)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int nCmp = 0;
  int nBad = 0;
  int lat[NS];          // done latency per stage, in cycles after its release
  int rel[NS];          // model: edge at which each stage is released
  int modelErrStg = 0;  // model: value oERR_STAGE holds outside a fresh error
  bit modelErr = 0;

  // Model: from the starting edge, derive release/ready/error edges with plain
  // arithmetic, then drive done levels and check every output each cycle.
  task automatic run_seq(input int base, input int softEdge, input int stopE);
    int t, R, Ee, es, ev, endE, se, eff;
    logic [NS-1:0] expRst;
    logic [1:0]    expEs;
    t = base + DLY + 1; R = INF; Ee = INF; es = modelErrStg;
    for (int i = 0; i < NS; i++) rel[i] = INF;
    for (int i = 0; i < NS; i++) begin
      if (Ee == INF) begin
        rel[i] = t;
        eff = (lat[i] < 1) ? 1 : lat[i];
        if (eff <= TO) begin
          if (i == NS - 1) R = t + eff;
          else             t = t + eff + DLY + 1;
        end else begin
          Ee = t + TO; es = i;
        end
      end
    end
    ev   = (R < Ee) ? R : Ee;
    endE = ev + 6;
    if (stopE < endE) endE = stopE;
    se = (softEdge == -2) ? int'($urandom_range(ev - 1, base + 1)) : softEdge;
    for (int e = base + 1; e <= endE; e++) begin
      for (int i = 0; i < NS; i++) iSTAGE_DONE[i] = (rel[i] != INF) && (e >= rel[i] + lat[i]);
      iSOFT_REQ = (e == se);
      @(posedge iCLK); #1;
      for (int i = 0; i < NS; i++) expRst[i] = (e < rel[i]) || (e >= Ee && i == es);
      expEs = (e >= Ee) ? es[1:0] : modelErrStg[1:0];
      nCmp += 5;
      if (oSTAGE_RST !== expRst) begin
        nBad++; $display("FAIL stage_rst edge+%0d: got %b want %b", e - base, oSTAGE_RST, expRst);
      end
      if (oALL_READY !== (e >= R)) begin
        nBad++; $display("FAIL all_ready edge+%0d: got %b want %b", e - base, oALL_READY, e >= R);
      end
      if (oBUSY !== (e < R && e < Ee)) begin
        nBad++; $display("FAIL busy edge+%0d: got %b want %b", e - base, oBUSY, e < R && e < Ee);
      end
      if (oERR !== (e >= Ee)) begin
        nBad++; $display("FAIL err edge+%0d: got %b want %b", e - base, oERR, e >= Ee);
      end
      if (oERR_STAGE !== expEs) begin
        nBad++; $display("FAIL err_stage edge+%0d: got %0d want %0d", e - base, oERR_STAGE, expEs);
      end
      @(negedge iCLK);
    end
    iSOFT_REQ = 1'b0;
    modelErr = (Ee <= endE);
    if (modelErr) modelErrStg = es;
  endtask

  task automatic do_reset(output int base);
    iRSTN = 1'b0; iSOFT_REQ = 1'b0; iSTAGE_DONE = '0;
    @(negedge iCLK);
    iRSTN = 1'b1;
    modelErrStg = 0;
    base = cyc;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
  endtask

  // Soft request from RUN or ERROR: one-edge entry into HOLD.
  task automatic soft_enter(output int base);
    iSOFT_REQ = 1'b1; iSTAGE_DONE = '1;
    @(posedge iCLK); #1;
    nCmp++;
    if ({oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'(modelErrStg)}) begin
      nBad++;
      $display("FAIL hold_entry: got rst=%b busy=%b rdy=%b err=%b stg=%0d want rst=111 busy=1 rdy=0 err=0 stg=%0d",
               oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE, modelErrStg);
    end
    @(negedge iCLK);
    iSOFT_REQ = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset;
    iRSTN = 1'b0;
    for (int n = 0; n < 2; n++) begin
      #1;
      nCmp++;
      if ({oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'd0}) begin
        nBad++;
        $display("FAIL reset_values: got rst=%b busy=%b rdy=%b err=%b stg=%0d want rst=111 busy=1 rdy=0 err=0 stg=0",
                 oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE);
      end
      @(negedge iCLK);
    end
  endtask

  task automatic test_nominal;
    int base;
    do_reset(base);
    set_lat(-100, -100, -100);
    run_seq(base, -1, INF);
  endtask

  task automatic test_soft_in_gap;
    int base;
    do_reset(base);
    set_lat(-100, -100, -100);
    run_seq(base, 13, INF);
  endtask

  task automatic test_timeout;
    int base;
    do_reset(base);
    set_lat(-100, 40, -100);
    run_seq(base, -1, INF);
  endtask

  task automatic test_soft_from_error;
    int base;
    soft_enter(base);
    set_lat(-100, -100, -100);
    run_seq(base, -1, INF);
  endtask

  task automatic test_async_reset;
    int base;
    do_reset(base);
    set_lat(-100, -100, 20);
    run_seq(base, -1, base + 35);
    #2 iRSTN = 1'b0;
    #1;
    nCmp++;
    if ({oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE} !== {3'b111, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      nBad++;
      $display("FAIL async_reset: got rst=%b busy=%b rdy=%b err=%b stg=%0d want rst=111 busy=1 rdy=0 err=0 stg=0",
               oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE);
    end
    @(negedge iCLK);
    do_reset(base);
    set_lat(-100, -100, -100);
    run_seq(base, -1, INF);
  endtask

`ifdef RSTSEQ_DONE_MONITOR_EN
  task automatic test_run_done;
    int base, j;
    logic [NS-1:0] m, expRst;
    do_reset(base);
    set_lat(-100, -100, -100);
    run_seq(base, -1, INF);
    for (int trial = 0; trial < 3; trial++) begin
      m = (trial == 0) ? 3'b101 : NS'($urandom_range(6, 0));
      j = NS;
      for (int i = NS - 1; i >= 0; i--) if (!m[i]) j = i;
      for (int i = 0; i < NS; i++) expRst[i] = (i >= j);
      iSTAGE_DONE = m;
      @(posedge iCLK); #1;
      nCmp++;
      if ({oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE} !== {expRst, 1'b0, 1'b0, 1'b1, 2'(j)}) begin
        nBad++;
        $display("FAIL done_monitor: got rst=%b busy=%b rdy=%b err=%b stg=%0d want rst=%b busy=0 rdy=0 err=1 stg=%0d",
                 oSTAGE_RST, oBUSY, oALL_READY, oERR, oERR_STAGE, expRst, j);
      end
      @(negedge iCLK);
      iSTAGE_DONE = '1;
      @(posedge iCLK); #1;
      nCmp++;
      if (oERR !== 1'b1 || oSTAGE_RST !== expRst) begin
        nBad++; $display("FAIL done_monitor_sticky: got err=%b rst=%b want err=1 rst=%b", oERR, oSTAGE_RST, expRst);
      end
      @(negedge iCLK);
      modelErrStg = j;
      soft_enter(base);
      run_seq(base, -1, INF);
    end
  endtask
`else
  task automatic test_run_done;
    int base;
    do_reset(base);
    set_lat(-100, -100, -100);
    run_seq(base, -1, INF);
    for (int n = 0; n < 10; n++) begin
      iSTAGE_DONE = NS'($urandom_range(7, 0));
      @(posedge iCLK); #1;
      nCmp++;
      if ({oSTAGE_RST, oBUSY, oALL_READY, oERR} !== {3'b000, 1'b0, 1'b1, 1'b0}) begin
        nBad++;
        $display("FAIL run_ignores_done: got rst=%b busy=%b rdy=%b err=%b want rst=000 busy=0 rdy=1 err=0",
                 oSTAGE_RST, oBUSY, oALL_READY, oERR);
      end
      @(negedge iCLK);
    end
    soft_enter(base);
    run_seq(base, -1, INF);
  endtask
`endif

  task automatic test_random;
    int base;
    for (int trial = 0; trial < 8; trial++) begin
      do_reset(base);
      for (int i = 0; i < NS; i++) lat[i] = int'($urandom_range(42, 0)) - 5;
      run_seq(base, -2, INF);
      if (modelErr && $urandom_range(1, 0) == 1) begin
        soft_enter(base);
        for (int i = 0; i < NS; i++) lat[i] = int'($urandom_range(42, 0)) - 5;
        run_seq(base, -2, INF);
      end
    end
  endtask

  initial begin
    @(negedge iCLK);
    test_reset;
    test_nominal;
    test_soft_in_gap;
    test_timeout;
    test_soft_from_error;
    test_async_reset;
    test_run_done;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d compares", nCmp);
    $fatal(1, "watchdog");
  end

endmodule
